issue_select_pipe: RTL and testbench
====================================

# issue_select_pipe

Parametrised oldest-first issue selector with registered issue lanes, per-pool FU credit tracking and EX backpressure. It sits between the RS and the issue/execute boundary. Each cycle it picks up to `N` ready RS entries, oldest first by ROB-relative age, within the free-FU credits of each category pool. It tells the RS which entries to clear, holds the picked entries in an output register until EX accepts them, and returns credits for issued work that a mispredict squashes.

## Interface
- `RS_SZ`, 16, RS entries scanned.
- `N`, 3, issue lanes (1..8).
- `ROB_IDX_W`, 5, ROB index width; age width is `ROB_IDX_W+1`.
- `NUM_CATS`, 5, category pools. `CAT_CSR` draws from the ALU pool.
- `FU_COUNT`, per-pool array, default {ALU:3, MULT:2, BRANCH:1, MEM:1}; credits at reset, max 15.
- `CNT_W`, 4, credit counter width.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low: low at a rising `clock` edge resets.
- `entries`  in  `RS_ENTRY[RS_SZ]`  RS contents (valid, src ready bits, rob_wrap, rob_idx, op_type.category).
- `head_wrap`  in  1  wrap bit of the ROB head.
- `mispredict`  in  1  squash pulse.
- `ex_ready`  in  1  EX accepts all valid output lanes this cycle.
- `fu_release`  in  `[NUM_CATS][CNT_W]`  FUs freed this cycle, per pool.
- `clear_valid`, `clear_idxs`  out  `[N]`, `RS_IDX[N]`  combinational RS clear requests.
- `issue_valid`, `issued_entries`  out  `[N]`, `RS_ENTRY[N]`  registered issue lanes.
- `fu_free`  out  `[NUM_CATS][CNT_W]`  current credits (registered).

## Operation
- **Ready test.** An entry is ready when valid, src1_ready and src2_ready are all set.
- **Age.** age = {rob_wrap ^ head_wrap, rob_idx}. The smaller value is older. Equal ages cannot legally occur; if they do, the lower RS index wins.
- **Per-pool limit.** A candidate has fewer than `fu_free[pool]` older ready entries in the same pool.
- **Global limit.** From all candidates, the `N` oldest are selected. Lane 0 gets the oldest, and lanes are packed contiguously.
- **Select-enable.** Selection is enabled only when all three hold:
  - `reset` is high,
  - `mispredict` is 0,
  - the output register is empty or `ex_ready` is 1.
  When disabled, `clear_valid` is 0 on every lane.
- **Enabled select.**
  - `clear_valid[k]` and `clear_idxs[k]` are driven for each selected lane.
  - Selected entries load into the output register at the next edge.
  - Unused lanes load with valid 0.
- **Stall.** When some `issue_valid` is 1 and `ex_ready` is 0, the output register holds its value and credits are unchanged except for releases.
- **Credits.**
  - Next credits = `fu_free` + `fu_release` − (lanes selected this cycle in that pool) + (squash return).
  - The result saturates at `FU_COUNT`; exceeding it is an assertion failure.
  - It never underflows, because selection respects the credits.
- **Mispredict.**
  - The output register clears at the next edge.
  - Credits are returned for every valid lane still held. Those lanes were not accepted: a lane counts as accepted only if `ex_ready` is 1 in the same cycle.
  - No selection happens in that cycle.
  - If `mispredict` and `ex_ready` are both 1, the held lanes count as accepted and no credits are returned.
- **Reset.** Outputs go to 0 and `fu_free` goes to `FU_COUNT`.

## Timing
- **Select-to-issue latency.** An entry selected at cycle t appears on `issue_valid` at t+1.
- **RS clear timing.** `clear_*` is combinational in cycle t, and the RS drops the entry at the t+1 edge. The block relies on that, so it never double-selects.
- **Credit timing.**
  - `fu_free` reflects consumption at t+1.
  - A `fu_release` in cycle t is usable for selection at t+1.
- **Back-to-back issue.** With `ex_ready` held at 1, full `N`-wide issue is possible every cycle.
- **Reset values.** `issue_valid`=0, `issued_entries`=0, `clear_valid`=0, `clear_idxs`=0, `fu_free`=`FU_COUNT`.
- **Mid-operation reset.** Reset during a stall discards the held lanes without returning credits; credits are reinitialised to `FU_COUNT` instead.
- **Age wrap-around.** A head_wrap toggle takes effect in the same cycle's selection.

## Test plan
- **Credit limit.** 4 ready ALU entries at rob_idx 7,3,9,5 (same wrap), ALU credit 3 → lanes 0..2 carry 3,5,7; `fu_free[ALU]`=0 next cycle; rob 9 waits.
- **Wrap straddle.** head_wrap=1, entries {wrap1,idx30} and {wrap0,idx2} → idx30 is issued first.
- **Stall and mispredict.** Stall 3 cycles with `ex_ready`=0 → outputs held and `clear_valid`=0; then `mispredict` with 2 MULT lanes held → `issue_valid`=0 next cycle and `fu_free[MULT]` back to 2.
- **Global width cap.** 5 ready entries across pools with ample credits, N=3 → exactly the 3 globally oldest are issued.
- **Release and consume in one cycle.** MEM credit 0, `fu_release[MEM]`=1, ready MEM entry → issued the following cycle, with credit back to 0.
- **Reset during stall.** Reset low during a stall → all outputs 0 and `fu_free`=`FU_COUNT` after one edge.

Source files
------------

// File: rtl/issue_select_pipe_if.sv
// Shared RS entry types and the issue selector's bundled port interface.
// Ports: RS contents, ROB head wrap, squash, EX ready, FU releases in;
//        RS clear requests, registered issue lanes, FU credits out.
package issue_select_pkg;
   localparam int ROB_IDX_W = 5;

   typedef enum logic [2:0] {
      CAT_ALU,
      CAT_MULT,
      CAT_BRANCH,
      CAT_MEM,
      CAT_CSR
   } cat_e;

   typedef struct packed {
      cat_e category;
   } op_type_t;

   typedef struct packed {
      logic                 valid;
      logic                 src1_ready;
      logic                 src2_ready;
      logic                 rob_wrap;
      logic [ROB_IDX_W-1:0] rob_idx;
      op_type_t             op_type;
   } rs_entry_t;
endpackage

interface issue_select_if #(
   parameter int RS_SZ    = 16,
   parameter int N        = 3,
   parameter int NUM_CATS = 5,
   parameter int CNT_W    = 4
);
   import issue_select_pkg::*;

   localparam int IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;

   rs_entry_t                      entries [RS_SZ];
   logic                           head_wrap;
   logic                           mispredict;
   logic                           ex_ready;
   logic [NUM_CATS-1:0][CNT_W-1:0] fu_release;
   logic [N-1:0]                   clear_valid;
   logic [N-1:0][IDX_W-1:0]        clear_idxs;
   logic [N-1:0]                   issue_valid;
   rs_entry_t [N-1:0]              issued_entries;
   logic [NUM_CATS-1:0][CNT_W-1:0] fu_free;

   modport master (
      output entries, head_wrap, mispredict, ex_ready, fu_release,
      input  clear_valid, clear_idxs, issue_valid, issued_entries,
      input  fu_free
   );

   modport slave (
      input  entries, head_wrap, mispredict, ex_ready, fu_release,
      output clear_valid, clear_idxs, issue_valid, issued_entries,
      output fu_free
   );
endinterface

// File: rtl/issue_select_pipe.sv
// Oldest-first N-wide issue selector with per-pool FU credits.
// Ports: clock, reset (sync, active-low), io (slave side of issue_select_if).
module issue_select_pipe
   import issue_select_pkg::*;
#(
   parameter int RS_SZ     = 16,
   parameter int N         = 3,
   parameter int ROB_IDX_W = 5,
   parameter int NUM_CATS  = 5,
   parameter int CNT_W     = 4,
   parameter logic [NUM_CATS-1:0][CNT_W-1:0] FU_COUNT =
      {4'd0, 4'd1, 4'd1, 4'd2, 4'd3}
) (
   input logic           clock,
   input logic           reset,
   issue_select_if.slave io
);
   localparam int IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
   localparam int PW    = (NUM_CATS > 1) ? $clog2(NUM_CATS) : 1;
   localparam int AGE_W = ROB_IDX_W + 1;
   localparam int CW    = 8;
   localparam int SW    = CNT_W + 5;

   logic [N-1:0]                   valid_q, valid_d;
   rs_entry_t [N-1:0]              ent_q, ent_d;
   logic [NUM_CATS-1:0][CNT_W-1:0] free_q, free_d;
   logic [N-1:0][IDX_W-1:0]        clr_idx;

   logic [RS_SZ-1:0] rdy, cand, sel;
   logic [AGE_W-1:0] age  [RS_SZ];
   logic [PW-1:0]    pool [RS_SZ];
   logic [CW-1:0]    pcnt [RS_SZ];
   logic [CW-1:0]    rank [RS_SZ];
   logic             en, squash, ovf;
   logic [SW-1:0]    sum;

   // CSR ops share the ALU pool.
   function automatic logic [PW-1:0] pool_of(rs_entry_t e);
      if (e.op_type.category == CAT_CSR) return PW'(CAT_ALU);
      return PW'(e.op_type.category);
   endfunction

   assign en = reset && !io.mispredict &&
               (!(|valid_q) || io.ex_ready);
   // Held lanes are returned only if EX did not take them.
   assign squash = io.mispredict && !io.ex_ready;

   always_comb begin
      for (int i = 0; i < RS_SZ; i++) begin
         rdy[i]  = io.entries[i].valid &&
                   io.entries[i].src1_ready &&
                   io.entries[i].src2_ready;
         age[i]  = {io.entries[i].rob_wrap ^ io.head_wrap,
                    io.entries[i].rob_idx};
         pool[i] = pool_of(io.entries[i]);
      end
   end

   // Age ties break toward the lower RS index, giving a strict
   // total order so ranks are unique and lanes pack densely.
   always_comb begin
      cand = '0;
      for (int i = 0; i < RS_SZ; i++) begin
         pcnt[i] = '0;
         for (int j = 0; j < RS_SZ; j++) begin
            if (j != i && rdy[j] && pool[j] == pool[i] &&
                (age[j] < age[i] ||
                 (age[j] == age[i] && j < i)))
               pcnt[i] = pcnt[i] + CW'(1);
         end
         cand[i] = rdy[i] && (pcnt[i] < CW'(free_q[pool[i]]));
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < RS_SZ; i++) begin
         rank[i] = '0;
         for (int j = 0; j < RS_SZ; j++) begin
            if (j != i && cand[j] &&
                (age[j] < age[i] ||
                 (age[j] == age[i] && j < i)))
               rank[i] = rank[i] + CW'(1);
         end
         sel[i] = en && cand[i] && (rank[i] < CW'(N));
      end
   end

   always_comb begin
      valid_d = '0;
      ent_d   = '0;
      clr_idx = '0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < RS_SZ; i++) begin
            if (sel[i] && rank[i] == CW'(k)) begin
               valid_d[k] = 1'b1;
               ent_d[k]   = io.entries[i];
               clr_idx[k] = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      free_d = free_q;
      ovf    = 1'b0;
      sum    = '0;
      for (int p = 0; p < NUM_CATS; p++) begin
         sum = SW'(free_q[p]) + SW'(io.fu_release[p]);
         for (int i = 0; i < RS_SZ; i++) begin
            if (sel[i] && pool[i] == PW'(p))
               sum = sum - SW'(1);
         end
         for (int k = 0; k < N; k++) begin
            if (squash && valid_q[k] &&
                pool_of(ent_q[k]) == PW'(p))
               sum = sum + SW'(1);
         end
         if (sum > SW'(FU_COUNT[p])) begin
            free_d[p] = FU_COUNT[p];
            ovf       = 1'b1;
         end else begin
            free_d[p] = sum[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
         ent_q   <= '0;
         free_q  <= FU_COUNT;
      end else begin
         free_q <= free_d;
         if (io.mispredict) begin
            valid_q <= '0;
            ent_q   <= '0;
         end else if (en) begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
         end
      end
   end

   // More credits than FUs means a release was double-counted.
   always_ff @(posedge clock) begin
      if (reset) assert (!ovf);
   end

   assign io.clear_valid    = valid_d;
   assign io.clear_idxs     = clr_idx;
   assign io.issue_valid    = valid_q;
   assign io.issued_entries = ent_q;
   assign io.fu_free        = free_q;
endmodule

// File: tb/tb_issue_select_pipe.sv
// Bench for issue_select_pipe: directed scenarios plus random traffic,
// checked against a queue-based reference model and a scoreboard.
module tb_issue_select_pipe;
   import issue_select_pkg::*;

   localparam int RS_SZ = 16;
   localparam int N     = 3;
   localparam int NC    = 5;
   localparam int CW    = 4;
   localparam int FU [NC] = '{3, 2, 1, 1, 0};

   typedef struct packed {
      logic [N-1:0]      v;
      rs_entry_t [N-1:0] e;
   } bundle_t;

   logic clk = 1'b0;
   logic rst_n;

   issue_select_if #(.RS_SZ(RS_SZ), .N(N), .NUM_CATS(NC), .CNT_W(CW)) io();

   issue_select_pipe #(
      .RS_SZ(RS_SZ), .N(N), .ROB_IDX_W(5), .NUM_CATS(NC), .CNT_W(CW),
      .FU_COUNT({4'd0, 4'd1, 4'd1, 4'd2, 4'd3})
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .io(io)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   rs_entry_t rs [RS_SZ];
   logic      hw;
   logic      c_mis, c_exr, c_rst;
   int        c_rel [NC];
   int        credit [NC];
   int        in_ex [NC];
   int        held [$];
   bundle_t   exp_q [$];
   bit        after_rst;
   logic [5:0] tail;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit is_rdy(rs_entry_t e);
      return e.valid && e.src1_ready && e.src2_ready;
   endfunction

   function automatic int age_of(rs_entry_t e, logic h);
      return int'(e.rob_wrap ^ h) * 32 + int'(e.rob_idx);
   endfunction

   function automatic int pool_m(rs_entry_t e);
      if (e.op_type.category == CAT_CSR) return 0;
      return int'(e.op_type.category);
   endfunction

   task automatic put(int i, logic w, int rob, cat_e c);
      rs[i].valid      = 1'b1;
      rs[i].src1_ready = 1'b1;
      rs[i].src2_ready = 1'b1;
      rs[i].rob_wrap   = w;
      rs[i].rob_idx    = 5'(rob);
      rs[i].op_type.category = c;
   endtask

   // One clock cycle: drive inputs, check combinational outputs and
   // credits, compute the expected pick, then advance the model.
   task automatic cycle();
      int      ord [$];
      int      picked [$];
      bit      used [RS_SZ];
      int      seen [NC];
      int      best;
      bit      en;
      bundle_t b;
      @(negedge clk);
      for (int i = 0; i < RS_SZ; i++) io.entries[i] = rs[i];
      io.head_wrap  = hw;
      io.mispredict = c_mis;
      io.ex_ready   = c_exr;
      for (int p = 0; p < NC; p++) io.fu_release[p] = CW'(c_rel[p]);
      rst_n = c_rst;
      #1;
      en = c_rst && !c_mis && (held.size() == 0 || c_exr);
      foreach (used[i]) used[i] = 1'b0;
      foreach (seen[p]) seen[p] = 0;
      if (en) begin
         for (int n = 0; n < RS_SZ; n++) begin
            best = -1;
            for (int i = 0; i < RS_SZ; i++) begin
               if (is_rdy(rs[i]) && !used[i] &&
                   (best < 0 ||
                    age_of(rs[i], hw) * RS_SZ + i <
                    age_of(rs[best], hw) * RS_SZ + best))
                  best = i;
            end
            if (best >= 0) begin
               used[best] = 1'b1;
               ord.push_back(best);
            end
         end
         foreach (ord[n]) begin
            if (seen[pool_m(rs[ord[n]])] < credit[pool_m(rs[ord[n]])] &&
                picked.size() < N)
               picked.push_back(ord[n]);
            seen[pool_m(rs[ord[n]])]++;
         end
      end
      chk("clear_valid", 64'(io.clear_valid),
          64'((1 << picked.size()) - 1));
      for (int k = 0; k < N; k++) begin
         if (k < picked.size())
            chk("clear_idx", 64'(io.clear_idxs[k]), 64'(picked[k]));
         else if (!c_rst)
            chk("clear_idx_rst", 64'(io.clear_idxs[k]), 64'd0);
      end
      chk("issue_valid_mask", 64'(io.issue_valid),
          64'((1 << held.size()) - 1));
      for (int p = 0; p < NC; p++)
         chk("fu_free", 64'(io.fu_free[p]), 64'(credit[p]));
      if (after_rst) begin
         chk("reset_issued", 64'(io.issued_entries), 64'd0);
         after_rst = 1'b0;
      end
      if (picked.size() > 0) begin
         b = '0;
         foreach (picked[k]) begin
            b.v[k] = 1'b1;
            b.e[k] = rs[picked[k]];
         end
         exp_q.push_back(b);
      end
      if (!c_rst) begin
         foreach (credit[p]) begin
            credit[p] = FU[p];
            in_ex[p]  = 0;
         end
         held = {};
         exp_q.delete();
         after_rst = 1'b1;
      end else begin
         if (held.size() > 0 && c_exr)
            foreach (held[k]) in_ex[held[k]]++;
         else if (c_mis)
            foreach (held[k]) credit[held[k]]++;
         for (int p = 0; p < NC; p++) begin
            credit[p] += c_rel[p];
            in_ex[p]  -= c_rel[p];
         end
         if (c_mis) begin
            held = {};
         end else if (en) begin
            held = {};
            foreach (picked[k]) begin
               held.push_back(pool_m(rs[picked[k]]));
               credit[pool_m(rs[picked[k]])]--;
               rs[picked[k]].valid = 1'b0;
            end
         end
      end
   endtask

   task automatic do_reset();
      foreach (rs[i]) rs[i] = '0;
      hw    = 1'b0;
      c_rst = 1'b0;
      c_exr = 1'b0;
      c_mis = 1'b0;
      foreach (c_rel[p]) c_rel[p] = 0;
      cycle();
      c_rst = 1'b1;
      c_exr = 1'b1;
   endtask

   task automatic alloc(int i);
      bit live;
      for (int n = 0; n < 64; n++) begin
         live = 1'b0;
         foreach (rs[j])
            if (rs[j].valid && {rs[j].rob_wrap, rs[j].rob_idx} == tail)
               live = 1'b1;
         if (live) tail = tail + 6'd1;
      end
      rs[i].valid      = 1'b1;
      rs[i].src1_ready = ($urandom_range(3) != 0);
      rs[i].src2_ready = ($urandom_range(3) != 0);
      rs[i].rob_wrap   = tail[5];
      rs[i].rob_idx    = tail[4:0];
      rs[i].op_type.category = cat_e'($urandom_range(4));
      tail = tail + 6'd1;
   endtask

   task automatic rnd_cycle();
      for (int i = 0; i < RS_SZ; i++) begin
         if (!rs[i].valid) begin
            if ($urandom_range(2) == 0) alloc(i);
         end else begin
            if ($urandom_range(3) == 0) rs[i].src1_ready = 1'b1;
            if ($urandom_range(3) == 0) rs[i].src2_ready = 1'b1;
         end
      end
      if ($urandom_range(31) == 0) hw = ~hw;
      c_rst = ($urandom_range(399) != 0);
      c_exr = c_rst && ($urandom_range(3) != 0);
      c_mis = c_rst && ($urandom_range(15) == 0);
      for (int p = 0; p < NC; p++)
         c_rel[p] = c_rst ? int'($urandom_range(in_ex[p])) : 0;
      cycle();
   endtask

   // Scoreboard monitor: a held bundle leaves when EX takes it or a
   // squash drops it; either way it must match what was selected.
   initial begin
      bundle_t b;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && |io.issue_valid &&
             (io.ex_ready || io.mispredict)) begin
            if (exp_q.size() == 0) begin
               chk("issue_unexpected", 64'(io.issue_valid), 64'd0);
            end else begin
               b = exp_q.pop_front();
               chk("issue_lanes", 64'(io.issue_valid), 64'(b.v));
               for (int k = 0; k < N; k++)
                  if (b.v[k])
                     chk("issue_entry", 64'(io.issued_entries[k]),
                         64'(b.e[k]));
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      io.head_wrap  = 1'b0;
      io.mispredict = 1'b0;
      io.ex_ready   = 1'b0;
      io.fu_release = '0;
      foreach (io.entries[i]) io.entries[i] = '0;
      foreach (credit[p]) begin
         credit[p] = FU[p];
         in_ex[p]  = 0;
      end
      after_rst = 1'b0;
      tail      = '0;

      // Credit limit: ALU rob 7,3,9,5 with 3 ALU credits.
      do_reset();
      put(0, 1'b0, 7, CAT_ALU);
      put(1, 1'b0, 3, CAT_ALU);
      put(2, 1'b0, 9, CAT_ALU);
      put(3, 1'b0, 5, CAT_ALU);
      cycle();
      @(posedge clk);
      #1;
      chk("credit_lane0", 64'(io.issued_entries[0].rob_idx), 64'd3);
      chk("credit_lane1", 64'(io.issued_entries[1].rob_idx), 64'd5);
      chk("credit_lane2", 64'(io.issued_entries[2].rob_idx), 64'd7);
      chk("credit_alu_zero", 64'(io.fu_free[0]), 64'd0);
      cycle();
      c_rel[0] = 3;
      cycle();
      c_rel[0] = 0;
      cycle();
      @(posedge clk);
      #1;
      chk("credit_rob9", 64'(io.issued_entries[0].rob_idx), 64'd9);

      // Wrap straddle: head_wrap=1, {1,30} is older than {0,2}.
      do_reset();
      hw = 1'b1;
      put(0, 1'b0, 2, CAT_ALU);
      put(1, 1'b1, 30, CAT_ALU);
      cycle();
      @(posedge clk);
      #1;
      chk("wrap_lane0", 64'(io.issued_entries[0].rob_idx), 64'd30);
      chk("wrap_lane1", 64'(io.issued_entries[1].rob_idx), 64'd2);
      cycle();

      // Stall 3 cycles then squash 2 held MULT lanes.
      do_reset();
      put(0, 1'b0, 4, CAT_MULT);
      put(1, 1'b0, 6, CAT_MULT);
      cycle();
      c_exr = 1'b0;
      put(2, 1'b0, 8, CAT_ALU);
      repeat (3) cycle();
      c_mis = 1'b1;
      cycle();
      c_mis = 1'b0;
      @(posedge clk);
      #1;
      chk("squash_valid", 64'(io.issue_valid), 64'd0);
      chk("squash_mult", 64'(io.fu_free[1]), 64'd2);
      c_exr = 1'b1;
      cycle();
      cycle();

      // Global width cap: five ready entries, three lanes.
      do_reset();
      put(0, 1'b0, 10, CAT_ALU);
      put(1, 1'b0, 4, CAT_MULT);
      put(2, 1'b0, 8, CAT_BRANCH);
      put(3, 1'b0, 2, CAT_MEM);
      put(4, 1'b0, 6, CAT_CSR);
      cycle();
      @(posedge clk);
      #1;
      chk("cap_lane0", 64'(io.issued_entries[0].rob_idx), 64'd2);
      chk("cap_lane1", 64'(io.issued_entries[1].rob_idx), 64'd4);
      chk("cap_lane2", 64'(io.issued_entries[2].rob_idx), 64'd6);
      cycle();
      cycle();

      // Release and consume a MEM credit.
      do_reset();
      put(0, 1'b0, 1, CAT_MEM);
      cycle();
      cycle();
      put(1, 1'b0, 3, CAT_MEM);
      c_rel[3] = 1;
      cycle();
      c_rel[3] = 0;
      cycle();
      @(posedge clk);
      #1;
      chk("mem_issued", 64'(io.issued_entries[0].rob_idx), 64'd3);
      chk("mem_credit", 64'(io.fu_free[3]), 64'd0);
      cycle();

      // Reset in the middle of a stall.
      do_reset();
      put(0, 1'b0, 5, CAT_ALU);
      put(1, 1'b0, 9, CAT_MULT);
      cycle();
      c_exr = 1'b0;
      cycle();
      c_rst = 1'b0;
      cycle();
      @(posedge clk);
      #1;
      chk("rst_stall_valid", 64'(io.issue_valid), 64'd0);
      chk("rst_stall_alu", 64'(io.fu_free[0]), 64'd3);
      chk("rst_stall_mult", 64'(io.fu_free[1]), 64'd2);
      c_rst = 1'b1;
      c_exr = 1'b1;
      cycle();

      // Random traffic.
      do_reset();
      repeat (3000) rnd_cycle();

      // Drain with nothing new arriving.
      foreach (rs[i]) rs[i] = '0;
      c_rst = 1'b1;
      c_exr = 1'b1;
      c_mis = 1'b0;
      foreach (c_rel[p]) c_rel[p] = 0;
      repeat (3) cycle();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
